// File: rtl/sequence_differencer.sv
// Recovers per-cycle terms from a stream of running sums: term = sum - previous sum (mod 2^W).
// Valid/ready on both sides; single registered output stage with a saturating emit counter.
module sequence_differencer #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_sum,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_term,
  output logic          out_first,
  output logic          out_wrap,
  output logic [CW-1:0] count
);

  typedef enum logic [0:0] {StEmpty, StRun} state_e;

  state_e       state_q;
  logic [W-1:0] prev_q;
  logic         accept;
  logic         out_hs;
  logic         is_first;
  logic [W-1:0] base;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign out_hs   = out_valid & out_ready;

  // A restart coinciding with an accept makes that very sum the first one.
  assign is_first = restart | (state_q == StEmpty);
  assign base     = is_first ? '0 : prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StEmpty;
      prev_q    <= '0;
      out_valid <= 1'b0;
      out_term  <= '0;
      out_first <= 1'b0;
      out_wrap  <= 1'b0;
      count     <= '0;
    end else begin
      if (accept) begin
        out_term  <= in_sum - base;
        out_wrap  <= (in_sum < base);
        out_first <= is_first;
        out_valid <= 1'b1;
        prev_q    <= in_sum;
        state_q   <= StRun;
      end else begin
        if (out_hs) begin
          out_valid <= 1'b0;
        end
        if (restart) begin
          prev_q  <= '0;
          state_q <= StEmpty;
        end
      end

      if (restart) begin
        count <= '0;
      end else if (out_hs && (count != '1)) begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sequence_differencer.sv
// Directed bench for sequence_differencer: one task per scenario, inline comparisons.
module tb_sequence_differencer;

  logic       clk;
  logic       reset;
  logic       restart;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_sum;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_term;
  logic       out_first;
  logic       out_wrap;
  logic [7:0] count;

  int checks;
  int errors;

  sequence_differencer #(.W(8), .CW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_term  (out_term),
    .out_first (out_first),
    .out_wrap  (out_wrap),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset    = 1'b1;
    restart  = 1'b0;
    in_valid = 1'b0;
    in_sum   = '0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++;
    if (out_term !== 8'h00) begin errors++; $display("FAIL reset_term: got %h want 00", out_term); end
    checks++;
    if ({out_first, out_wrap} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got %b want 00", {out_first, out_wrap});
    end
    checks++;
    if (count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] sums [3]  = '{8'd5, 8'd12, 8'd20};
    logic [7:0] terms [3] = '{8'd5, 8'd7, 8'd8};
    logic       firsts [3] = '{1'b1, 1'b0, 1'b0};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_sum   = sums[i];
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_term !== terms[i] || out_first !== firsts[i]) begin
        errors++;
        $display("FAIL basic_term%0d: got v=%b t=%0d f=%b want v=1 t=%0d f=%b",
                 i, out_valid, out_term, out_first, terms[i], firsts[i]);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 8'd3 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_count: got c=%0d v=%b want c=3 v=0", count, out_valid);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] sums [5]  = '{8'hF0, 8'h10, 8'hFF, 8'h00, 8'h00};
    logic [7:0] terms [5] = '{8'hF0, 8'h20, 8'hEF, 8'h01, 8'h00};
    logic       wraps [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_sum   = sums[i];
      @(negedge clk);
      checks++;
      if (out_term !== terms[i] || out_wrap !== wraps[i]) begin
        errors++;
        $display("FAIL wrap_term%0d: got t=%h w=%b want t=%h w=%b",
                 i, out_term, out_wrap, terms[i], wraps[i]);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sum    = 8'd50;
    @(negedge clk);
    in_sum = 8'd60;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_term !== 8'd50 || count !== 8'd0) begin
        errors++;
        $display("FAIL bp_hold%0d: got rdy=%b v=%b t=%0d c=%0d want rdy=0 v=1 t=50 c=0",
                 i, in_ready, out_valid, out_term, count);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_term !== 8'd10 || out_first !== 1'b0 || count !== 8'd1) begin
      errors++;
      $display("FAIL bp_release: got t=%0d f=%b c=%0d want t=10 f=0 c=1", out_term, out_first, count);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || count !== 8'd2) begin
      errors++; $display("FAIL bp_drain: got v=%b c=%0d want v=0 c=2", out_valid, count);
    end
  endtask

  task automatic test_restart();
    apply_reset();
    in_valid = 1'b1;
    in_sum   = 8'd10;
    @(negedge clk);
    in_sum = 8'd30;
    @(negedge clk);
    checks++;
    if (out_term !== 8'd20) begin errors++; $display("FAIL rs_pre: got %0d want 20", out_term); end
    restart = 1'b1;
    in_sum  = 8'd7;
    @(negedge clk);
    restart  = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_term !== 8'd7 || out_first !== 1'b1 || out_wrap !== 1'b0 || count !== 8'd0) begin
      errors++;
      $display("FAIL rs_first: got t=%0d f=%b w=%b c=%0d want t=7 f=1 w=0 c=0",
               out_term, out_first, out_wrap, count);
    end
    @(negedge clk);
    checks++;
    if (count !== 8'd1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rs_count: got c=%0d v=%b want c=1 v=0", count, out_valid);
    end
  endtask

  task automatic test_inverse();
    logic [7:0] terms [3] = '{8'd3, 8'd250, 8'd9};
    logic [7:0] acc;
    apply_reset();
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      acc      = acc + terms[i];
      in_valid = 1'b1;
      in_sum   = acc;
      @(negedge clk);
      checks++;
      if (out_term !== terms[i]) begin
        errors++; $display("FAIL inv_term%0d: got %0d want %0d", i, out_term, terms[i]);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sum    = 8'd99;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b want 1", out_valid); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 8'd0) begin
      errors++; $display("FAIL mid_cleared: got v=%b c=%0d want v=0 c=0", out_valid, count);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sum    = 8'd4;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_term !== 8'd4 || out_first !== 1'b1) begin
      errors++; $display("FAIL mid_next: got t=%0d f=%b want t=4 f=1", out_term, out_first);
    end
    @(negedge clk);
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 260; i++) begin
      in_valid = 1'b1;
      in_sum   = 8'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d want 255", count); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    restart   = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_restart();
    test_inverse();
    test_reset_midstream();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
